// File: rtl/basics_cmd_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : basics_cmd_initiator_pkg
// Description : Shared types and constants for the command initiator:
//               controller state encoding, response codes, default payload
//               depth and the EID sequencing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package basics_cmd_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_ADDR  = 3'd1,
        ST_TX_BYTE  = 3'd2,
        ST_TX_GAP   = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_RX_BYTE  = 3'd5,
        ST_RX_GAP   = 3'd6,
        ST_FINISH   = 3'd7
    } state_e;

    localparam logic [7:0] c_CODE_ACK    = 8'h00;
    localparam logic [7:0] c_CODE_NAK    = 8'h01;
    localparam int         c_MAX_PAYLOAD = 8;

    // EID sequence skips 0x00 so that 0x00 can mean "never issued".
    function automatic logic [7:0] next_eid(input logic [7:0] eid);
        return (eid == 8'hFF) ? 8'h01 : eid + 8'h01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/basics_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : basics_cmd_initiator
// Description : Issues an addressed command frame (addr, EID, length,
//               payload) on the master bus, then collects and decodes the
//               responder's reply or times out waiting for it.
// Revision    : 1.0 - initial release
// ============================================================================
module basics_cmd_initiator
    import basics_cmd_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_PAYLOAD    = c_MAX_PAYLOAD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic       pl_wr,
    input  logic [2:0] pl_waddr,
    input  logic [7:0] pl_wdata,
    output logic [7:0] ma_data,
    output logic       ma_data_valid,
    output logic       ma_frame_valid,
    input  logic [7:0] sl_data,
    input  logic       sl_arb_request,
    output logic       sl_arb_grant,
    output logic       sl_data_latch,
    output logic       busy,
    output logic       done,
    output logic       rsp_ack,
    output logic       rsp_nak,
    output logic       rsp_timeout,
    output logic       rsp_eid_err,
    output logic [7:0] rsp_len,
    input  logic [2:0] rsp_rd_addr,
    output logic [7:0] rsp_rd_data
);

    localparam logic [3:0]  c_LEN_MAX  = 4'(MAX_PAYLOAD);
    localparam logic [8:0]  c_RX_DEPTH = 9'(MAX_PAYLOAD);
    localparam logic [15:0] c_TIMEOUT  = 16'(TIMEOUT_CYCLES);

    state_e      state_q;
    logic        busy_q, done_q;
    logic [7:0]  ma_data_q;
    logic        ma_data_valid_q, ma_frame_valid_q;
    logic        grant_q, latch_q;
    logic [7:0]  eid_q;
    logic [3:0]  len_q;
    logic        addr_ph_q;     // second address cycle
    logic        len_sent_q;    // length byte already on the bus
    logic [3:0]  tx_rem_q;      // bytes still to send after the current one
    logic [2:0]  pl_ptr_q;
    logic [15:0] to_cnt_q;
    logic [8:0]  rx_idx_q;
    logic [7:0]  code_q;
    logic        eid_match_q;
    logic        rsp_ack_q, rsp_nak_q, rsp_timeout_q, rsp_eid_err_q;
    logic [7:0]  rsp_len_q;
    logic [7:0]  pl_buf_q  [MAX_PAYLOAD];
    logic [7:0]  rsp_buf_q [MAX_PAYLOAD];

    logic [7:0]  eid_d;
    logic [8:0]  rx_idx_d;
    logic [3:0]  w_len_eff;
    logic [8:0]  w_rx_off;

    // Next EID, saturating receive index, clamped length, payload offset
    always_comb begin
        eid_d     = next_eid(eid_q);
        rx_idx_d  = (rx_idx_q == '1) ? rx_idx_q : rx_idx_q + 9'd1;
        w_len_eff = (cmd_len > c_LEN_MAX) ? c_LEN_MAX : cmd_len;
        w_rx_off  = rx_idx_q - 9'd3;
    end

    // Controller: frame transmit, response receive and status capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            ma_data_q        <= 8'h00;
            ma_data_valid_q  <= 1'b0;
            ma_frame_valid_q <= 1'b0;
            grant_q          <= 1'b0;
            latch_q          <= 1'b0;
            eid_q            <= 8'h00;
            len_q            <= 4'h0;
            addr_ph_q        <= 1'b0;
            len_sent_q       <= 1'b0;
            tx_rem_q         <= 4'h0;
            pl_ptr_q         <= 3'd0;
            to_cnt_q         <= 16'h0000;
            rx_idx_q         <= 9'd0;
            code_q           <= c_CODE_ACK;
            eid_match_q      <= 1'b0;
            rsp_ack_q        <= 1'b0;
            rsp_nak_q        <= 1'b0;
            rsp_timeout_q    <= 1'b0;
            rsp_eid_err_q    <= 1'b0;
            rsp_len_q        <= 8'h00;
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                pl_buf_q[i]  <= 8'h00;
                rsp_buf_q[i] <= 8'h00;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pl_wr) begin
                        pl_buf_q[pl_waddr] <= pl_wdata;
                    end
                    if (start) begin
                        state_q          <= ST_TX_ADDR;
                        busy_q           <= 1'b1;
                        eid_q            <= eid_d;
                        len_q            <= w_len_eff;
                        addr_ph_q        <= 1'b0;
                        ma_frame_valid_q <= 1'b1;
                        ma_data_q        <= cmd_addr;
                        rx_idx_q         <= 9'd0;
                        eid_match_q      <= 1'b0;
                        rsp_ack_q        <= 1'b0;
                        rsp_nak_q        <= 1'b0;
                        rsp_timeout_q    <= 1'b0;
                        rsp_eid_err_q    <= 1'b0;
                        rsp_len_q        <= 8'h00;
                    end
                end
                ST_TX_ADDR: begin
                    addr_ph_q <= 1'b1;
                    if (addr_ph_q) begin
                        state_q         <= ST_TX_BYTE;
                        ma_data_q       <= eid_q;
                        ma_data_valid_q <= 1'b1;
                        len_sent_q      <= 1'b0;
                        tx_rem_q        <= len_q + 4'd1;
                        pl_ptr_q        <= 3'd0;
                    end
                end
                ST_TX_BYTE: begin
                    state_q         <= ST_TX_GAP;
                    ma_data_valid_q <= 1'b0;
                end
                ST_TX_GAP: begin
                    if (tx_rem_q == 4'h0) begin
                        state_q          <= ST_WAIT_RSP;
                        ma_frame_valid_q <= 1'b0;
                        ma_data_q        <= 8'h00;
                        to_cnt_q         <= 16'h0000;
                    end else begin
                        state_q         <= ST_TX_BYTE;
                        ma_data_valid_q <= 1'b1;
                        tx_rem_q        <= tx_rem_q - 4'd1;
                        len_sent_q      <= 1'b1;
                        if (!len_sent_q) begin
                            ma_data_q <= {4'h0, len_q};
                        end else begin
                            ma_data_q <= pl_buf_q[pl_ptr_q];
                            pl_ptr_q  <= pl_ptr_q + 3'd1;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (sl_arb_request) begin
                        state_q <= ST_RX_BYTE;
                        grant_q <= 1'b1;
                        latch_q <= 1'b1;
                    end else if ((to_cnt_q + 16'd1) == c_TIMEOUT) begin
                        state_q       <= ST_FINISH;
                        done_q        <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                ST_RX_BYTE: begin
                    state_q  <= ST_RX_GAP;
                    latch_q  <= 1'b0;
                    rx_idx_q <= rx_idx_d;
                    case (rx_idx_q)
                        9'd0:    code_q      <= (sl_data == c_CODE_ACK) ? c_CODE_ACK : c_CODE_NAK;
                        9'd1:    eid_match_q <= (sl_data == eid_q);
                        9'd2:    rsp_len_q   <= sl_data;
                        default: begin
                            // Payload beyond the buffer depth is drained, not stored.
                            if (w_rx_off < c_RX_DEPTH) begin
                                rsp_buf_q[w_rx_off[2:0]] <= sl_data;
                            end
                        end
                    endcase
                end
                ST_RX_GAP: begin
                    if (sl_arb_request) begin
                        state_q <= ST_RX_BYTE;
                        latch_q <= 1'b1;
                    end else begin
                        state_q       <= ST_FINISH;
                        grant_q       <= 1'b0;
                        done_q        <= 1'b1;
                        rsp_ack_q     <= (code_q == c_CODE_ACK);
                        rsp_nak_q     <= (code_q == c_CODE_NAK);
                        rsp_eid_err_q <= !eid_match_q;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ma_data        = ma_data_q;
    assign ma_data_valid  = ma_data_valid_q;
    assign ma_frame_valid = ma_frame_valid_q;
    assign sl_arb_grant   = grant_q;
    assign sl_data_latch  = latch_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign rsp_ack        = rsp_ack_q;
    assign rsp_nak        = rsp_nak_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign rsp_eid_err    = rsp_eid_err_q;
    assign rsp_len        = rsp_len_q;
    assign rsp_rd_data    = rsp_buf_q[rsp_rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_basics_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_basics_cmd_initiator
// Description : Directed self-checking bench for basics_cmd_initiator with a
//               scripted responder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_basics_cmd_initiator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [3:0] cmd_len = 4'h0;
    logic       pl_wr = 1'b0;
    logic [2:0] pl_waddr = 3'd0;
    logic [7:0] pl_wdata = 8'h00;
    logic [7:0] ma_data;
    logic       ma_data_valid, ma_frame_valid;
    logic [7:0] sl_data;
    logic       sl_arb_request, sl_arb_grant, sl_data_latch;
    logic       busy, done;
    logic       rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err;
    logic [7:0] rsp_len;
    logic [2:0] rsp_rd_addr = 3'd0;
    logic [7:0] rsp_rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Responder script: bytes are offered while any remain, popped on latch.
    logic [7:0] rsp_mem [0:15];
    int         rsp_n   = 0;
    int         rsp_idx = 0;

    // Captured frame from the last command
    logic [7:0] cap_bytes [0:15];
    int         cap_n;
    bit         cap_fmt_ok;
    int         cap_wait;
    logic       cap_done, cap_done_next;
    logic [3:0] cap_stat_tx;

    basics_cmd_initiator #(
        .TIMEOUT_CYCLES (100),
        .MAX_PAYLOAD    (8)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .pl_wr          (pl_wr),
        .pl_waddr       (pl_waddr),
        .pl_wdata       (pl_wdata),
        .ma_data        (ma_data),
        .ma_data_valid  (ma_data_valid),
        .ma_frame_valid (ma_frame_valid),
        .sl_data        (sl_data),
        .sl_arb_request (sl_arb_request),
        .sl_arb_grant   (sl_arb_grant),
        .sl_data_latch  (sl_data_latch),
        .busy           (busy),
        .done           (done),
        .rsp_ack        (rsp_ack),
        .rsp_nak        (rsp_nak),
        .rsp_timeout    (rsp_timeout),
        .rsp_eid_err    (rsp_eid_err),
        .rsp_len        (rsp_len),
        .rsp_rd_addr    (rsp_rd_addr),
        .rsp_rd_data    (rsp_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) rsp_idx <= 0;
        else if (sl_data_latch && rsp_idx < rsp_n) rsp_idx <= rsp_idx + 1;
    end
    assign sl_arb_request = (rsp_idx < rsp_n);
    assign sl_data        = (rsp_idx < rsp_n) ? rsp_mem[rsp_idx[3:0]] : 8'h00;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; pl_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_payload(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_wr = 1'b1; pl_waddr = a; pl_wdata = d;
        @(negedge clk);
        pl_wr = 1'b0;
    endtask

    // Launch one command and record the frame shape, bytes and completion timing.
    // With poke set, a second start and a payload write are attempted while busy.
    task automatic issue_and_capture(input logic [7:0] addr, input logic [3:0] len, input bit poke);
        int cyc;
        cap_n = 0; cap_fmt_ok = 1'b1; cap_wait = -1; cap_done = 1'b0; cap_done_next = 1'b0;
        @(negedge clk);
        start = 1'b1; cmd_addr = addr; cmd_len = len;
        @(negedge clk);
        start = 1'b0;
        cap_stat_tx = {rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err};
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin start = 1'b0; pl_wr = 1'b0; end
            if (!(ma_frame_valid === 1'b1 && ma_data_valid === 1'b0 && ma_data === addr)) cap_fmt_ok = 1'b0;
            if (i == 0 && poke) begin
                start = 1'b1; cmd_addr = ~addr; cmd_len = 4'hF;
                pl_wr = 1'b1; pl_waddr = 3'd0; pl_wdata = 8'hEE;
            end
            @(negedge clk);
        end
        cyc = 0;
        while (ma_frame_valid === 1'b1 && cyc < 40) begin
            if (ma_data_valid !== 1'b1) cap_fmt_ok = 1'b0;
            else if (cap_n < 16) begin cap_bytes[cap_n] = ma_data; cap_n++; end
            @(negedge clk);
            if (ma_frame_valid !== 1'b1 || ma_data_valid !== 1'b0) cap_fmt_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (ma_data !== 8'h00) cap_fmt_ok = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        cap_wait = cyc;
        cap_done = done;
        @(negedge clk);
        cap_done_next = done;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ma_frame_valid !== 1'b0 || ma_data_valid !== 1'b0 || ma_data !== 8'h00)
            $display("FAIL reset_master_bus got fv=%b dv=%b d=%h exp 0/0/00", ma_frame_valid, ma_data_valid, ma_data); else n_pass++;
        n_checks++; if (sl_arb_grant !== 1'b0 || sl_data_latch !== 1'b0)
            $display("FAIL reset_grant got grant=%b latch=%b exp 0/0", sl_arb_grant, sl_data_latch); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_busy_done got busy=%b done=%b exp 0/0", busy, done); else n_pass++;
        n_checks++; if ({rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err} !== 4'b0000 || rsp_len !== 8'h00)
            $display("FAIL reset_status got %b len=%h exp 0000 len=00", {rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err}, rsp_len); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            rsp_rd_addr = 3'(i);
            #1;
            n_checks++; if (rsp_rd_data !== 8'h00)
                $display("FAIL reset_rsp_buf[%0d] got %h exp 00", i, rsp_rd_data); else n_pass++;
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_b [0:3];
        exp_b = '{8'h01, 8'h02, 8'h00, 8'h02};
        do_reset();
        load_payload(3'd0, 8'h00);
        load_payload(3'd1, 8'h02);
        rsp_mem[0] = 8'h00; rsp_mem[1] = 8'h01; rsp_mem[2] = 8'h00; rsp_n = 3;
        issue_and_capture(8'h76, 4'd2, 1'b0);
        n_checks++; if (cap_fmt_ok !== 1'b1) $display("FAIL basic_frame_shape got %b exp 1", cap_fmt_ok); else n_pass++;
        n_checks++; if (cap_n !== 4) $display("FAIL basic_byte_count got %0d exp 4", cap_n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_bytes[i] !== exp_b[i]) $display("FAIL basic_byte[%0d] got %h exp %h", i, cap_bytes[i], exp_b[i]); else n_pass++;
        end
        n_checks++; if (cap_done !== 1'b1 || cap_done_next !== 1'b0)
            $display("FAIL basic_done_pulse got %b%b exp 10", cap_done, cap_done_next); else n_pass++;
        n_checks++; if ({rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err} !== 4'b1000)
            $display("FAIL basic_status got %b exp 1000", {rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err}); else n_pass++;
        n_checks++; if (rsp_len !== 8'h00) $display("FAIL basic_rsp_len got %h exp 00", rsp_len); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_payload_resp();
        do_reset();
        load_payload(3'd0, 8'h63);
        rsp_mem[0] = 8'h00; rsp_mem[1] = 8'h01; rsp_mem[2] = 8'h01; rsp_mem[3] = 8'h63; rsp_n = 4;
        issue_and_capture(8'h49, 4'd1, 1'b0);
        n_checks++; if (cap_n !== 3 || cap_bytes[0] !== 8'h01 || cap_bytes[1] !== 8'h01 || cap_bytes[2] !== 8'h63)
            $display("FAIL pl_frame got n=%0d %h %h %h exp n=3 01 01 63", cap_n, cap_bytes[0], cap_bytes[1], cap_bytes[2]); else n_pass++;
        n_checks++; if ({rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err} !== 4'b1000)
            $display("FAIL pl_status got %b exp 1000", {rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err}); else n_pass++;
        n_checks++; if (rsp_len !== 8'h01) $display("FAIL pl_rsp_len got %h exp 01", rsp_len); else n_pass++;
        rsp_rd_addr = 3'd0;
        #1;
        n_checks++; if (rsp_rd_data !== 8'h63) $display("FAIL pl_rsp_data0 got %h exp 63", rsp_rd_data); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        rsp_n = 0;
        issue_and_capture(8'h10, 4'd0, 1'b0);
        n_checks++; if (cap_n !== 2 || cap_bytes[0] !== 8'h01 || cap_bytes[1] !== 8'h00)
            $display("FAIL to_frame got n=%0d %h %h exp n=2 01 00", cap_n, cap_bytes[0], cap_bytes[1]); else n_pass++;
        n_checks++; if (cap_done !== 1'b1 || cap_wait !== 100)
            $display("FAIL to_latency got done=%b cycles=%0d exp done=1 cycles=100", cap_done, cap_wait); else n_pass++;
        n_checks++; if ({rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err} !== 4'b0010)
            $display("FAIL to_status got %b exp 0010", {rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err}); else n_pass++;
    endtask

    task automatic test_len_clamp();
        for (int i = 0; i < 8; i++) load_payload(3'(i), 8'hA0 + 8'(i));
        rsp_mem[0] = 8'h00; rsp_mem[1] = 8'h02; rsp_mem[2] = 8'h0A;
        for (int i = 0; i < 10; i++) rsp_mem[3 + i] = 8'hB0 + 8'(i);
        rsp_n = 13;
        issue_and_capture(8'h2C, 4'd12, 1'b0);
        n_checks++; if (cap_stat_tx !== 4'b0000)
            $display("FAIL clamp_status_cleared got %b exp 0000", cap_stat_tx); else n_pass++;
        n_checks++; if (cap_n !== 10 || cap_bytes[0] !== 8'h02 || cap_bytes[1] !== 8'h08)
            $display("FAIL clamp_header got n=%0d eid=%h len=%h exp n=10 eid=02 len=08", cap_n, cap_bytes[0], cap_bytes[1]); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (cap_bytes[2 + i] !== 8'hA0 + 8'(i))
                $display("FAIL clamp_payload[%0d] got %h exp %h", i, cap_bytes[2 + i], 8'hA0 + 8'(i)); else n_pass++;
        end
        n_checks++; if ({rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err} !== 4'b1000 || rsp_len !== 8'h0A)
            $display("FAIL clamp_rsp_status got %b len=%h exp 1000 len=0a", {rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err}, rsp_len); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            rsp_rd_addr = 3'(i);
            #1;
            n_checks++; if (rsp_rd_data !== 8'hB0 + 8'(i))
                $display("FAIL clamp_rsp_buf[%0d] got %h exp %h", i, rsp_rd_data, 8'hB0 + 8'(i)); else n_pass++;
        end
    endtask

    task automatic test_nak_eid();
        do_reset();
        rsp_mem[0] = 8'h01; rsp_mem[1] = 8'h55; rsp_mem[2] = 8'h00; rsp_n = 3;
        issue_and_capture(8'h20, 4'd0, 1'b0);
        n_checks++; if ({rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err} !== 4'b0101)
            $display("FAIL nak_eid_status got %b exp 0101", {rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err}); else n_pass++;
        rsp_mem[0] = 8'h7E; rsp_mem[1] = 8'h02; rsp_mem[2] = 8'h00; rsp_n = 3;
        issue_and_capture(8'h21, 4'd0, 1'b0);
        n_checks++; if ({rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err} !== 4'b0100)
            $display("FAIL other_code_status got %b exp 0100", {rsp_ack, rsp_nak, rsp_timeout, rsp_eid_err}); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        do_reset();
        load_payload(3'd0, 8'h11);
        rsp_mem[0] = 8'h00; rsp_mem[1] = 8'h01; rsp_mem[2] = 8'h00; rsp_n = 3;
        issue_and_capture(8'h5A, 4'd1, 1'b1);
        n_checks++; if (cap_fmt_ok !== 1'b1) $display("FAIL busy_frame_shape got %b exp 1", cap_fmt_ok); else n_pass++;
        n_checks++; if (cap_n !== 3 || cap_bytes[1] !== 8'h01 || cap_bytes[2] !== 8'h11)
            $display("FAIL busy_frame_bytes got n=%0d %h %h exp n=3 01 11", cap_n, cap_bytes[1], cap_bytes[2]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_eid;
        do_reset();
        rsp_mem[0] = 8'h00; rsp_n = 1;
        for (int k = 0; k < 256; k++) begin
            exp_eid = 8'((k % 255) + 1);
            issue_and_capture(8'(k), 4'd0, 1'b1);
            n_checks++; if (cap_n !== 2 || cap_bytes[0] !== exp_eid)
                $display("FAIL b2b_eid[%0d] got n=%0d eid=%h exp n=2 eid=%h", k, cap_n, cap_bytes[0], exp_eid); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int k;
        do_reset();
        rsp_n = 0;
        @(negedge clk);
        start = 1'b1; cmd_addr = 8'h33; cmd_len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (ma_data_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_checks++; if (ma_data_valid !== 1'b1) $display("FAIL mid_reach_tx_byte got %b exp 1", ma_data_valid); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ma_frame_valid !== 1'b0 || busy !== 1'b0 || ma_data !== 8'h00)
            $display("FAIL mid_tx_reset got fv=%b busy=%b d=%h exp 0/0/00", ma_frame_valid, busy, ma_data); else n_pass++;
        rst = 1'b0;
        rsp_mem[0] = 8'h00; rsp_mem[1] = 8'h01; rsp_mem[2] = 8'h05;
        for (int i = 3; i < 8; i++) rsp_mem[i] = 8'(i);
        rsp_n = 8;
        @(negedge clk);
        start = 1'b1; cmd_addr = 8'h34; cmd_len = 4'd0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (sl_arb_grant !== 1'b1 && k < 60) begin @(negedge clk); k++; end
        n_checks++; if (sl_arb_grant !== 1'b1) $display("FAIL mid_reach_rx got %b exp 1", sl_arb_grant); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (sl_arb_grant !== 1'b0 || sl_data_latch !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_rx_reset got grant=%b latch=%b busy=%b exp 0/0/0", sl_arb_grant, sl_data_latch, busy); else n_pass++;
        rst = 1'b0;
        rsp_mem[0] = 8'h00; rsp_mem[1] = 8'h01; rsp_mem[2] = 8'h00; rsp_n = 3;
        issue_and_capture(8'h44, 4'd0, 1'b0);
        n_checks++; if (cap_bytes[0] !== 8'h01 || rsp_eid_err !== 1'b0)
            $display("FAIL mid_next_eid got eid=%h err=%b exp 01/0", cap_bytes[0], rsp_eid_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_payload_resp();
        test_timeout();
        test_len_clamp();
        test_nak_eid();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
